// File: rtl/bit_pack_out.sv
// bit_pack_out
//   Packs variable-length, LSB-first bit chunks into fixed OUT_W-bit words.
//   Bits are appended at the current fill level of an OUT_W+IN_W accumulator.
//   A full word moves to a single-entry output register whenever that register
//   is free. A chunk flagged in_last switches to FLUSH. FLUSH drains the
//   remaining bits, the last of them as a zero-padded word tagged out_last.
//
// Ports
//   clk, rst             rising-edge clock; asynchronous active-low reset
//   in_valid/in_ready    input chunk handshake
//   in_data, in_len      chunk bits (LSB-first) and number of valid bits
//   in_last              chunk closes the stream
//   out_valid/out_ready  output word handshake
//   out_data             packed word, LSB-first
//   out_last             word closes the stream
//   out_last_len         valid bits in the closing word, 0 otherwise
module bit_pack_out #(
  parameter int IN_W  = 256,
  parameter int OUT_W = 512,
  parameter int LEN_W = $clog2(IN_W) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic [LEN_W-1:0]       in_len,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_last,
  output logic [$clog2(OUT_W):0] out_last_len
);

  localparam int ACC_W  = OUT_W + IN_W;
  localparam int CNT_W  = $clog2(ACC_W);
  localparam int LAST_W = $clog2(OUT_W) + 1;

  localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);
  localparam logic [LEN_W-1:0] IN_W_L  = LEN_W'(IN_W);

  typedef enum logic {ACC, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [LAST_W-1:0]   out_last_len_q, out_last_len_d;

  logic [LEN_W-1:0]    len_eff;
  logic [IN_W-1:0]     chunk_masked;
  logic                accept;
  logic                slot_free;

  // Oversized lengths saturate to a full chunk.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > IN_W_L) ? IN_W_L : len;
  endfunction

  // Shifting all-ones by IN_W yields zero, so a full-length chunk keeps every bit.
  assign len_eff      = clamp_len(in_len);
  assign chunk_masked = in_data & ~({IN_W{1'b1}} << len_eff);

  assign in_ready  = (state_q == ACC) && (cnt_q < OUT_W_C) && rst;
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid_q || out_ready;

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign out_last_len = out_last_len_q;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_last_d     = out_last_q;
    out_last_len_d = out_last_len_q;

    // A word leaving with nothing behind it empties the slot.
    if (out_valid_q && out_ready) begin
      out_valid_d    = 1'b0;
      out_last_d     = 1'b0;
      out_last_len_d = '0;
    end

    // Accepting needs cnt < OUT_W and emitting needs cnt >= OUT_W (or FLUSH,
    // where in_ready is low), so the two branches never compete.
    if (accept) begin
      acc_d = acc_q | (ACC_W'(chunk_masked) << cnt_q);
      cnt_d = cnt_q + CNT_W'(len_eff);
      if (in_last) begin
        state_d = FLUSH;
      end
    end else if (slot_free) begin
      if ((state_q == ACC && cnt_q >= OUT_W_C) ||
          (state_q == FLUSH && cnt_q > OUT_W_C)) begin
        out_valid_d    = 1'b1;
        out_data_d     = acc_q[OUT_W-1:0];
        out_last_d     = 1'b0;
        out_last_len_d = '0;
        acc_d          = acc_q >> OUT_W;
        cnt_d          = cnt_q - OUT_W_C;
      end else if (state_q == FLUSH) begin
        // Bits at and above cnt are always zero, so the low word is already padded.
        out_valid_d    = 1'b1;
        out_data_d     = acc_q[OUT_W-1:0];
        out_last_d     = 1'b1;
        out_last_len_d = LAST_W'(cnt_q);
        acc_d          = '0;
        cnt_d          = '0;
        state_d        = ACC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ACC;
      acc_q          <= '0;
      cnt_q          <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_last_q     <= 1'b0;
      out_last_len_q <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_last_q     <= out_last_d;
      out_last_len_q <= out_last_len_d;
    end
  end

endmodule

// File: tb/tb_bit_pack_out.sv
// Directed testbench for bit_pack_out with IN_W=256, OUT_W=512.
module tb_bit_pack_out;

  localparam int IN_W   = 256;
  localparam int OUT_W  = 512;
  localparam int LEN_W  = 9;
  localparam int LAST_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic [LEN_W-1:0]  in_len;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic [LAST_W-1:0] out_last_len;

  int errors = 0;
  int checks = 0;

  logic [IN_W-1:0] pa, pb, c1, c2, c3, p1, p2, p3, p4;
  logic [OUT_W-1:0] wd;
  logic             wl;
  logic [LAST_W-1:0] wn;

  always #5 clk = ~clk;

  bit_pack_out #(.IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_len       (in_len),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_last_len (out_last_len)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic [LEN_W-1:0] len, input logic last);
    int n;
    n = 0;
    in_data  = d;
    in_len   = len;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end else begin
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
    in_len   = '0;
    in_last  = 1'b0;
  endtask

  // Waits for a word, captures it and spends one clock so out_ready can take it.
  task automatic wait_out(output logic [OUT_W-1:0] d, output logic last, output logic [LAST_W-1:0] len);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_out_timeout: out_valid=%b required 1", out_valid);
      d = '0; last = 1'b0; len = '0;
    end else begin
      d = out_data; last = out_last; len = out_last_len;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    checks++; if (out_last_len !== '0) begin errors++; $display("FAIL rst_out_last_len: got %0d want 0", out_last_len); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_two_full();
    out_ready = 1'b1;
    pa = {32{8'hAA}};
    pb = {32{8'h55}};
    send(pa, 9'd256, 1'b0);
    send(pb, 9'd256, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL two_latency: out_valid=%b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL two_ready_full: in_ready=%b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL two_valid: out_valid=%b want 1", out_valid); end
    checks++; if (out_data !== {pb, pa}) begin errors++; $display("FAIL two_data: got %h want %h", out_data, {pb, pa}); end
    checks++; if (out_last !== 1'b0 || out_last_len !== '0) begin errors++; $display("FAIL two_last: got %b/%0d want 0/0", out_last, out_last_len); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL two_pulse: out_valid=%b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL two_ready_again: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_three_200();
    out_ready = 1'b1;
    c1 = '1;
    c2 = {32{8'hA5}};
    c3 = {32{8'h3C}};
    send(c1, 9'd200, 1'b0);
    send(c2, 9'd200, 1'b0);
    send(c3, 9'd200, 1'b1);
    wait_out(wd, wl, wn);
    checks++; if (wd !== {c3[111:0], c2[199:0], c1[199:0]}) begin errors++; $display("FAIL t200_w1_data: got %h want %h", wd, {c3[111:0], c2[199:0], c1[199:0]}); end
    checks++; if (wl !== 1'b0 || wn !== '0) begin errors++; $display("FAIL t200_w1_last: got %b/%0d want 0/0", wl, wn); end
    wait_out(wd, wl, wn);
    checks++; if (wd !== {424'b0, c3[199:112]}) begin errors++; $display("FAIL t200_w2_data: got %h want %h", wd, {424'b0, c3[199:112]}); end
    checks++; if (wl !== 1'b1 || wn !== 10'd88) begin errors++; $display("FAIL t200_w2_last: got %b/%0d want 1/88", wl, wn); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t200_back_to_acc: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_exact_last();
    out_ready = 1'b1;
    pa = {16{16'hC0DE}};
    pb = {16{16'hBEEF}};
    send(pa, 9'd300, 1'b0);   // length above IN_W counts as IN_W
    send(pb, 9'd256, 1'b1);
    wait_out(wd, wl, wn);
    checks++; if (wd !== {pb, pa}) begin errors++; $display("FAIL exact_data: got %h want %h", wd, {pb, pa}); end
    checks++; if (wl !== 1'b1 || wn !== 10'd512) begin errors++; $display("FAIL exact_last: got %b/%0d want 1/512", wl, wn); end
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exact_no_extra: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    p1 = {32{8'h11}};
    p2 = {32{8'h22}};
    p3 = {32{8'h33}};
    p4 = {32{8'h44}};
    send(p1, 9'd256, 1'b0);
    send(p2, 9'd256, 1'b0);
    send(p3, 9'd256, 1'b0);
    send(p4, 9'd256, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== {p2, p1} || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b data=%h want 1/0/%h", i, out_valid, in_ready, out_data, {p2, p1});
      end
      tick();
    end
    out_ready = 1'b1;
    wait_out(wd, wl, wn);
    checks++; if (wd !== {p2, p1} || wl !== 1'b0) begin errors++; $display("FAIL bp_w1: got %h/%b want %h/0", wd, wl, {p2, p1}); end
    wait_out(wd, wl, wn);
    checks++; if (wd !== {p4, p3}) begin errors++; $display("FAIL bp_w2_data: got %h want %h", wd, {p4, p3}); end
    checks++; if (wl !== 1'b1 || wn !== 10'd512) begin errors++; $display("FAIL bp_w2_last: got %b/%0d want 1/512", wl, wn); end
  endtask

  task automatic test_zero_last();
    out_ready = 1'b1;
    pa = {8{32'h0123_4567}};
    pb = {8{32'h89AB_CDEF}};
    send('1, 9'd0, 1'b0);     // empty chunk must leave no trace
    send(pa, 9'd256, 1'b0);
    send(pb, 9'd256, 1'b0);
    wait_out(wd, wl, wn);
    checks++; if (wd !== {pb, pa} || wl !== 1'b0) begin errors++; $display("FAIL zero_w1: got %h/%b want %h/0", wd, wl, {pb, pa}); end
    send('1, 9'd0, 1'b1);
    wait_out(wd, wl, wn);
    checks++; if (wd !== '0) begin errors++; $display("FAIL zero_w2_data: got %h want 0", wd); end
    checks++; if (wl !== 1'b1 || wn !== 10'd0) begin errors++; $display("FAIL zero_w2_last: got %b/%0d want 1/0", wl, wn); end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    send(p1, 9'd256, 1'b0);
    send(p2, 9'd256, 1'b0);
    send(p3, 9'd256, 1'b0);
    send(p4, 9'd44, 1'b1);    // FLUSH with 300 bits buffered, previous word still pending
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rf_pre: valid=%b ready=%b want 1/0", out_valid, in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL rf_async: valid=%b last=%b want 0/0", out_valid, out_last); end
    checks++; if (out_data !== '0 || in_ready !== 1'b0) begin errors++; $display("FAIL rf_clear: data=%h ready=%b want 0/0", out_data, in_ready); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rf_release: in_ready=%b want 1", in_ready); end
    out_ready = 1'b1;
    send('1, 9'd8, 1'b1);
    wait_out(wd, wl, wn);
    checks++; if (wd !== 512'hFF) begin errors++; $display("FAIL rf_data: got %h want ff", wd); end
    checks++; if (wl !== 1'b1 || wn !== 10'd8) begin errors++; $display("FAIL rf_last: got %b/%0d want 1/8", wl, wn); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_full();
    test_three_200();
    test_exact_last();
    test_backpressure();
    test_zero_last();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_pack_out.md
BIT_PACK_OUT -- requirements
Module: bit_pack_out

Interface
REQ-001 Parameter IN_W, default 256, maximum valid bits per input chunk; IN_W SHALL be <= OUT_W.
REQ-002 Parameter OUT_W, default 512, output word width in bits.
REQ-003 Parameter LEN_W, default $clog2(IN_W)+1, width of in_len.
REQ-004 Ports, in order:
  - clk  in  1  single clock, rising edge.
  - rst  in  1  asynchronous, active-low reset (0 = reset).
  - in_valid  in  1  input chunk valid.
  - in_ready  out  1  block accepts a chunk this cycle.
  - in_data  in  IN_W  packed bits, LSB-first; only bits [in_len-1:0] are meaningful.
  - in_len  in  LEN_W  number of valid bits in in_data, 0..IN_W.
  - in_last  in  1  chunk is the final one of the stream.
  - out_valid  out  1  out_data holds a word.
  - out_ready  in  1  downstream accepts the word.
  - out_data  out  OUT_W  packed output word, LSB-first.
  - out_last  out  1  word is the final word of the stream.
  - out_last_len  out  $clog2(OUT_W)+1  valid bits in the final word; 0 on non-last words.

Function
REQ-005 An input chunk SHALL be accepted exactly when in_valid && in_ready at a rising edge.
REQ-006 An output word SHALL be transferred exactly when out_valid && out_ready at a rising edge.
REQ-007 The block SHALL hold an accumulator of OUT_W+IN_W bits and a bit count cnt, range 0..OUT_W+IN_W-1.
REQ-008 On acceptance, in_data bits at and above in_len SHALL be masked to 0.
REQ-009 On acceptance, the masked chunk SHALL be ORed into the accumulator at bit offset cnt, and cnt SHALL increase by in_len.
REQ-010 An in_len greater than IN_W SHALL be treated as IN_W.
REQ-011 A chunk with in_len=0 and in_last=0 SHALL be accepted with no state change.
REQ-012 The output stage SHALL be one register slot. The slot is free when out_valid=0 or a transfer occurs this cycle.
REQ-013 Word emission: when cnt >= OUT_W and the slot is free, the block SHALL, at that edge:
  - load out_data with accumulator[OUT_W-1:0];
  - shift the accumulator right by OUT_W;
  - decrement cnt by OUT_W;
  - set out_valid=1.
REQ-014 Emission SHALL occur in the cycle after the acceptance that brings cnt to >= OUT_W, giving a latency of 1 clock when the slot is free.
REQ-015 in_ready SHALL equal (state==ACC) && (cnt < OUT_W) && rst, combinationally.
REQ-016 Acceptance and emission in the same edge SHALL NOT occur, because acceptance requires cnt < OUT_W and emission requires cnt >= OUT_W.
REQ-017 The state machine SHALL have two states, ACC (reset state) and FLUSH.
REQ-018 ACC -> FLUSH SHALL occur on acceptance of a chunk with in_last=1; the chunk's bits are included.
REQ-019 Emission rules in FLUSH, when the slot is free:
  - cnt > OUT_W: emit a full word per REQ-013 with out_last=0.
  - cnt == OUT_W: emit that word with out_last=1 and out_last_len=OUT_W.
  - cnt < OUT_W: emit accumulator[OUT_W-1:0] with bits at and above cnt zero, out_last=1, out_last_len=cnt.
  - cnt == 0: emit an all-zero word with out_last=1 and out_last_len=0.
REQ-020 After the out_last word is loaded, state SHALL return to ACC with cnt=0 and the accumulator cleared.
REQ-021 in_ready SHALL stay 0 for the whole of FLUSH.
REQ-022 While out_valid=1 and out_ready=0:
  - out_data, out_last and out_last_len SHALL hold stable;
  - cnt and the accumulator SHALL not shift.
REQ-023 out_last and out_last_len SHALL be 0 on every non-last word.
REQ-024 No input bits SHALL be dropped or duplicated. The total bits across all words equals the sum of accepted in_len values, padded only in the final word.

Reset
REQ-025 On rst=0, asynchronously:
  - state SHALL become ACC;
  - cnt and the accumulator SHALL become 0;
  - out_valid, out_last, out_data and out_last_len SHALL become 0;
  - in_ready SHALL be 0.
REQ-026 Reset asserted mid-stream or mid-FLUSH SHALL discard all buffered bits and any pending output word without emitting them.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (IN_W=256, OUT_W=512)
REQ-028 Two chunks of len 256 (0xAA.. then 0x55..), out_ready=1 -> one word {0x55..,0xAA..} with out_valid pulsed 1 cycle after the second acceptance, out_last=0.
REQ-029 Three chunks of len 200, last on the third, out_ready=1 -> two words:
  - word 1: full, out_last=0;
  - word 2: out_last=1, out_last_len=88, bits [511:88]=0.
REQ-030 Chunks 256, 256 (last), out_ready=1 -> single word with out_last=1 and out_last_len=512; no extra empty word.
REQ-031 out_ready=0 for 10 cycles with a full word pending -> out_data stable, in_ready=0 once cnt>=512, no data loss after out_ready=1.
REQ-032 Zero-length last chunk directly after exactly 512 bits have already been emitted -> all-zero word with out_last=1 and out_last_len=0.
REQ-033 rst pulsed low during FLUSH with cnt=300 -> out_valid=0 immediately; the next stream of one 8-bit last chunk yields out_last_len=8.
